egress_buffer: RTL
==================

Name: egress_buffer

Overview:
- Consumes the granted output of an arbitrated FIFO bank: a one-hot grant vector plus the granted word.
- Captures each granted word with its source index in a small show-ahead FIFO and drains it to a ready/valid sink.
- Drives back-pressure (blk) into the DWRR arbiter's block input so the arbiter stops granting before the buffer overflows.
- Keeps per-source accepted-word counters and sticky error flags for verification and debug.

Parameters:
- NUM_REQS, `NUM_REQS (default 2): number of arbitrated sources; width of gnt.
- WIDTH, `FIFO_DWIDTH (default 8): data word width.
- DEPTH, `FIFO_DEPTH (default 4): buffer entries; power of two, >= 2.
- SLACK, 1: blk asserts when occupancy >= DEPTH-SLACK; 1 <= SLACK < DEPTH.
- CNTW, 8: width of each per-source counter.
- Derived, not overridable: SRCW = max(1, clog2(NUM_REQS)); OCCW = clog2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- gnt  input  NUM_REQS  grant vector from the arbiter; expected one-hot or zero.
- data_in  input  WIDTH  granted word; valid only when gnt is nonzero.
- blk  output  1  back-pressure to the arbiter; registered.
- out_valid  output  1  head entry available.
- out_ready  input  1  sink accepts the head entry when out_valid && out_ready.
- out_data  output  WIDTH  head entry data.
- out_src  output  SRCW  head entry source index.
- count  output  OCCW  current occupancy, 0..DEPTH.
- gnt_cnt  output  NUM_REQS*CNTW  flat per-source accepted counters; source i occupies bits [(i+1)*CNTW-1 : i*CNTW].
- ovf  output  1  sticky: a write was dropped because the buffer was full.
- err  output  1  sticky: gnt was multi-hot.

Behaviour:
- Reset, synchronous on posedge with rst=1:
  - count=0; rd/wr pointers=0; out_valid=0; blk=0; ovf=0; err=0; all gnt_cnt=0.
  - out_data and out_src are don't-care while out_valid=0.
  - rst overrides every same-cycle write or pop. Reset mid-operation discards all contents.
- Write request (wr_req) = |gnt.
- Source index:
  - Index of the lowest set bit of gnt.
  - If more than one bit is set, err is set (sticky) and the lowest-index source is still used.
- Pop = out_valid && out_ready.
- Write acceptance:
  - Accepted if count < DEPTH.
  - Also accepted if count == DEPTH and a pop occurs in the same cycle, i.e. a simultaneous push/pop at full is legal.
  - Otherwise the write is dropped, ovf is set, and no counter increments.
- Accepted write:
  - Stores {src, data_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
  - gnt_cnt[src] increments by 1, wrapping modulo 2^CNTW.
- Pop: rd_ptr advances, wrapping modulo DEPTH.
- Count update:
  - count_next = count + accepted_write - pop.
  - Simultaneous write and pop leaves count unchanged. Simultaneous write and pop at count==0 is impossible because out_valid=0.
- Output timing:
  - Show-ahead: out_valid = (count != 0), out_data/out_src = entry at rd_ptr.
  - Latency from grant to out_valid is 1 cycle; there is no same-cycle bypass.
  - out_data and out_src are stable while out_valid && !out_ready.
- blk:
  - Registered: blk <= (count_next >= DEPTH-SLACK).
  - Deasserts the cycle after count_next drops below the threshold.
- Grants arriving while blk=1 are still processed normally. blk is advisory; overflow protection is the write-drop rule.
- ovf and err clear only on rst.

Test Plan:
- Reset, then gnt=2'b01, data_in=8'hA5 for one cycle, out_ready=0 -> next cycle: out_valid=1, out_data=8'hA5, out_src=0, count=1, gnt_cnt[7:0]=1, blk=0.
- Three further grants (gnt=2'b10, data 8'h01, 8'h02, 8'h03), out_ready=0 -> count=4, blk=1 from the cycle after count_next first reaches 3, gnt_cnt[15:8]=3.
- At count=4, gnt=2'b01 with data 8'hFF, out_ready=0 -> write dropped, ovf=1, count stays 4, gnt_cnt[7:0] stays 1.
- At count=4, gnt=2'b10 with data 8'h77 and out_ready=1 in the same cycle -> A5 popped, 8'h77 accepted, count=4; draining thereafter yields 01, 02, 03, 77 with out_src=1 each; blk drops the cycle after count_next reaches 2.
- gnt=2'b11, data_in=8'h3C -> err=1, entry stored with out_src=0, gnt_cnt[7:0] increments by 1.
- With count=3, ovf=1 and err=1, assert rst for one cycle together with a grant -> count=0, out_valid=0, blk=0, ovf=0, err=0, gnt_cnt=0; the grant is ignored.

Source files
------------

// File: rtl/egress_buffer_if.sv
// Handshake bundle between the arbitrated FIFO bank, the egress buffer and its sink.
// The buffer takes the slave side; the arbiter/sink model takes the master side.
interface egress_buffer_if #(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned WIDTH    = 8
);
  localparam int unsigned SRCW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_REQS-1:0] gnt;
  logic [WIDTH-1:0]    data_in;
  logic                blk;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic [SRCW-1:0]     out_src;

  modport master (
    output gnt, data_in, out_ready,
    input  blk, out_valid, out_data, out_src
  );

  modport slave (
    input  gnt, data_in, out_ready,
    output blk, out_valid, out_data, out_src
  );
endinterface

// File: rtl/egress_buffer.sv
// Show-ahead FIFO capturing granted words with their source index, with registered
// back-pressure, per-source accept counters and sticky overflow/multi-hot flags.
module egress_buffer #(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SLACK    = 1,
  parameter int unsigned CNTW     = 8,
  localparam int unsigned SRCW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int unsigned OCCW    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  egress_buffer_if.slave           bus,
  output logic [OCCW-1:0]          count,
  output logic [NUM_REQS*CNTW-1:0] gnt_cnt,
  output logic                     ovf,
  output logic                     err
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned ENTW = SRCW + WIDTH;

  logic [ENTW-1:0] mem_q [DEPTH];
  logic [ENTW-1:0] mem_d [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCCW-1:0] count_q, count_d;
  logic [CNTW-1:0] gnt_cnt_q [NUM_REQS];
  logic [CNTW-1:0] gnt_cnt_d [NUM_REQS];
  logic            blk_q, blk_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic            wr_req;
  logic            multi_hot;
  logic            pop;
  logic            accept;
  logic [SRCW-1:0] src;

  // Lowest set grant bit wins, so a multi-hot grant still lands on one source.
  always_comb begin
    src = '0;
    for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
      if (bus.gnt[i]) src = SRCW'(i);
    end
  end

  always_comb begin
    wr_req    = |bus.gnt;
    multi_hot = $countones(bus.gnt) > 1;
    pop       = (count_q != '0) && bus.out_ready;
    // A push at full is fine when the head leaves in the same cycle.
    accept    = wr_req && ((count_q < OCCW'(DEPTH)) || pop);

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    gnt_cnt_d = gnt_cnt_q;

    if (accept) begin
      mem_d[wr_ptr_q] = {src, bus.data_in};
      wr_ptr_d        = wr_ptr_q + PTRW'(1);
      gnt_cnt_d[src]  = gnt_cnt_q[src] + CNTW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTRW'(1);

    count_d = count_q + OCCW'(accept) - OCCW'(pop);
    blk_d   = count_d >= OCCW'(DEPTH - SLACK);
    ovf_d   = ovf_q | (wr_req & ~accept);
    err_d   = err_q | multi_hot;
  end

  // Storage is never cleared; count_q alone decides what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      blk_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(NUM_REQS); i++) gnt_cnt_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      blk_q     <= blk_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  always_comb begin
    gnt_cnt = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) gnt_cnt[i*CNTW +: CNTW] = gnt_cnt_q[i];
  end

  assign bus.out_valid              = count_q != '0;
  assign {bus.out_src, bus.out_data} = mem_q[rd_ptr_q];
  assign bus.blk                    = blk_q;
  assign count                      = count_q;
  assign ovf                        = ovf_q;
  assign err                        = err_q;

endmodule
